mux_n_to_1_reg: RTL
===================

// Module: mux_n_to_1_reg
// PURPOSE
//  Parametrised N:1 data multiplexer with a registered output stage and valid/ready handshake.
//  Successor to the combinational 2:1 mux: generalised to N channels of WIDTH bits.
//  Adds backpressure and one pipeline register.
//  Sits between N producer streams and one consumer; the selected or arbitrated channel is forwarded.
// PARAMETERS
//  N      4  number of input channels, 2..16
//  WIDTH  8  data bits per channel, >=1
//  SEL_W  $clog2(N) (localparam)  width of channel index
// PORTS
//  clk        in   1        single clock, all logic on rising edge
//  rst        in   1        synchronous, active-high reset
//  in_data    in   N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
//  in_valid   in   N        per-channel valid
//  in_ready   out  N        per-channel ready, combinational
//  sel        in   SEL_W    channel select (ignored when MUXN_RR_EN defined)
//  out_data   out  WIDTH    registered data
//  out_chan   out  SEL_W    registered index of the channel that produced out_data
//  out_valid  out  1        registered valid
//  out_ready  in   1        consumer ready
// BEHAVIOUR
//  - Reset: out_valid=0, out_data=0, out_chan=0, rr_ptr=0; in_ready=0 during the rst cycle.
//  - Stage can accept: take = !out_valid | out_ready.
//  - grant = chosen channel index; gvalid = grant is legal & in_valid[grant].
//  - in_ready[i] = take & (i==grant) & !rst; all other bits are 0. At most one bit is set.
//  - Transfer on edge when take & gvalid: out_data<=in_data[grant], out_chan<=grant, out_valid<=1.
//  - take & !gvalid: out_valid<=0 and out_data is held.
//  - Output handshake: out_valid & out_ready completes a beat.
//  - Stall (out_valid & !out_ready): out_data/out_chan/out_valid are held stable.
//  - Latency 1 clk from input handshake to out_valid.
//  - Throughput 1 beat/clk when out_ready is held high. There are no bubbles on simultaneous pop+push.
//  - Fixed mode: grant = sel.
//    - sel>=N (non-power-of-2 N) makes the grant illegal: no transfer, in_ready all 0.
//    - sel may change every cycle; the sel value at the edge decides.
//  - rst asserted mid-stall: the held beat is discarded; outputs take reset values next edge.
//  - Data is never duplicated or dropped: each in handshake yields exactly one out handshake.
// CONFIGURATION
//  MUXN_RR_EN defined: round-robin arbitration; sel is ignored.
//    - grant = first i with in_valid[i], scanning rr_ptr, rr_ptr+1, ... with wrap at N-1 -> 0.
//    - rr_ptr <= (grant+1) mod N, only on an accepted transfer; otherwise held.
//    - No valid channel: no grant, in_ready all 0, rr_ptr held.
//  MUXN_RR_EN undefined: fixed select via sel as above; no rr_ptr register.
// TESTING
//  1. rst=1 for 2 clks with all in_valid=1 -> out_valid=0, out_data=0, in_ready=0.
//  2. Fixed mode, N=4 W=8: in_data={8'h44,8'h33,8'h22,8'h11}, all valid, sel=2, out_ready=1
//     -> in_ready=4'b0100; next clk out_data=8'h33, out_chan=2, out_valid=1.
//  3. Stall: out_ready=0 for 3 clks after a beat; change in_data[2] -> out_data stays 8'h33,
//     in_ready=0. out_ready=1 -> new beat the next clk.
//  4. Sweep sel 0..3 every clk with out_ready=1 -> out_chan sequence 0,1,2,3 back-to-back.
//     Same check at N=3 with sel=3 -> no transfer.
//  5. MUXN_RR_EN, all 4 valid, out_ready=1 -> out_chan 0,1,2,3,0. in_valid=4'b1010 from ptr=0
//     -> 1,3,1. in_valid=0 -> out_valid drops.
//  6. rst pulsed while out_valid=1 & out_ready=0 -> out_valid=0 next clk. Scoreboard: beats in == beats out.

Source files
------------

// File: rtl/mux_n_to_1_reg.sv
// mux_n_to_1_reg: N:1 multiplexer with one registered output stage and a
// valid/ready handshake on both sides.
// Optional feature macro: MUXN_RR_EN
//   undefined -> the channel is chosen by sel (out-of-range sel grants nothing)
//   defined   -> round-robin among valid channels starting at rr_ptr; sel ignored
module mux_n_to_1_reg #(
  parameter int N = 4,
  parameter int WIDTH = 8,
  localparam int SEL_W = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic [SEL_W-1:0]   sel,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_chan,
  output logic               out_valid,
  input  logic               out_ready
);

  logic             take;
  logic             grant_ok;
  logic             gvalid;
  logic [SEL_W-1:0] grant;
  logic [WIDTH-1:0] grant_data;

  // The stage can load whenever it is empty or its beat leaves this cycle,
  // which gives back-to-back beats without a bubble.
  assign take = !out_valid || out_ready;

`ifdef MUXN_RR_EN
  logic [SEL_W-1:0] rr_ptr;
  logic [N-1:0]     rot_valid;
  int               scan_idx;

  // Rotate the valid vector so bit 0 is rr_ptr, then take the first set bit.
  always_comb begin
    grant     = '0;
    grant_ok  = 1'b0;
    scan_idx  = 0;
    rot_valid = N'({in_valid, in_valid} >> rr_ptr);
    for (int k = 0; k < N; k++) begin
      if (!grant_ok && rot_valid[k]) begin
        grant_ok = 1'b1;
        scan_idx = int'(rr_ptr) + k;
        if (scan_idx >= N) scan_idx = scan_idx - N;
        grant = SEL_W'(scan_idx);
      end
    end
  end

  // The pointer moves past the winner only when its beat is actually taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (take && gvalid) begin
      rr_ptr <= (grant == SEL_W'(N - 1)) ? '0 : grant + 1'b1;
    end
  end
`else
  // Fixed select; an index past the last channel (non-power-of-2 N) grants nothing.
  assign grant    = sel;
  assign grant_ok = (int'(sel) < N);
`endif

  // Fetch data and valid of the granted channel.
  always_comb begin
    grant_data = '0;
    gvalid     = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (grant_ok && (grant == SEL_W'(i))) begin
        grant_data = in_data[i*WIDTH +: WIDTH];
        gvalid     = in_valid[i];
      end
    end
  end

  // Ready goes only to the granted channel, and never while in reset.
  always_comb begin
    in_ready = '0;
    for (int i = 0; i < N; i++) begin
      in_ready[i] = take && grant_ok && !rst && (grant == SEL_W'(i));
    end
  end

  // Output register: load on transfer, empty on take without data, hold on stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
    end else if (take) begin
      if (gvalid) begin
        out_valid <= 1'b1;
        out_data  <= grant_data;
        out_chan  <= grant;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
